noc_router_ingress: RTL and testbench

- Router datapath wrapped around the NxN wavefront switch allocator.
- Holds one flit FIFO per input port and drives the request matrix from each head flit's destination plus per-output credit availability.
- Consumes the returned grant matrix to pop the granted heads and register them onto the output ports.
- Tracks downstream credits per output port so no output is ever overrun.

---
 rtl/noc_router_ingress.sv | 162 ++++++++++++++++
 tb/tb_noc_router_ingress.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_router_ingress.sv
// noc_router_ingress: per-input flit FIFOs, request/grant glue and
// per-output credit tracking around an NxN switch allocator.
module noc_router_ingress #(
  parameter int DIM_N   = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4,
  localparam int DIMW   = (DIM_N > 1) ? $clog2(DIM_N) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DIM_N-1:0]             in_vld_i,
  output logic [DIM_N-1:0]             in_rdy_o,
  input  logic [DIM_N-1:0][DATA_W-1:0] in_data_i,
  input  logic [DIM_N-1:0][DIMW-1:0]   in_dest_i,
  output logic [DIM_N-1:0][DIM_N-1:0]  req_o,
  input  logic [DIM_N-1:0][DIM_N-1:0]  grn_i,
  output logic [DIM_N-1:0]             out_vld_o,
  output logic [DIM_N-1:0][DATA_W-1:0] out_data_o,
  input  logic [DIM_N-1:0]             credit_i,
  output logic                         err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(CREDITS + 1);

  localparam logic [PW:0]   FULLC = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   CNT1  = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR1  = PW'(1);
  localparam logic [CW-1:0] CMAX  = CW'(CREDITS);
  localparam logic [CW-1:0] CR1   = CW'(1);
  localparam logic [DIMW:0] NLIM  = (DIMW + 1)'(DIM_N);

  logic [DATA_W-1:0] mem_data [DIM_N][DEPTH];
  logic [DIMW-1:0]   mem_dest [DIM_N][DEPTH];
  logic [PW-1:0]     wptr     [DIM_N];
  logic [PW-1:0]     rptr     [DIM_N];
  logic [PW:0]       count    [DIM_N];
  logic [CW-1:0]     credit   [DIM_N];

  logic [DIM_N-1:0] full;
  logic [DIM_N-1:0] empty;
  logic [DIM_N-1:0] push;
  logic [DIM_N-1:0] bad;
  logic [DIM_N-1:0] store;
  logic [DIM_N-1:0] pop;
  logic [DIM_N-1:0] col_grant;
  logic [DIM_N-1:0] ovf;

  logic [DIM_N-1:0][DIM_N-1:0]  g;
  logic [DIM_N-1:0][DATA_W-1:0] head_data;
  logic [DIM_N-1:0][DIMW-1:0]   head_dest;
  logic [DIM_N-1:0][DATA_W-1:0] odata_nxt;

  // Ready looks only at registered occupancy, never at this cycle's pop.
  always_comb begin
    full      = '0;
    empty     = '0;
    push      = '0;
    bad       = '0;
    store     = '0;
    head_data = '0;
    head_dest = '0;
    for (int i = 0; i < DIM_N; i++) begin
      full[i]      = (count[i] == FULLC);
      empty[i]     = (count[i] == '0);
      push[i]      = in_vld_i[i] && !full[i];
      bad[i]       = push[i] && ({1'b0, in_dest_i[i]} >= NLIM);
      store[i]     = push[i] && !bad[i];
      head_data[i] = mem_data[i][rptr[i]];
      head_dest[i] = mem_dest[i][rptr[i]];
    end
  end

  assign in_rdy_o = ~full;

  always_comb begin
    req_o = '0;
    for (int i = 0; i < DIM_N; i++) begin
      for (int j = 0; j < DIM_N; j++) begin
        req_o[i][j] = !empty[i]
                   && (head_dest[i] == DIMW'(j))
                   && (credit[j] != '0);
      end
    end
  end

  assign g = grn_i & req_o;

  always_comb begin
    pop       = '0;
    col_grant = '0;
    odata_nxt = out_data_o;
    ovf       = '0;
    for (int i = 0; i < DIM_N; i++) begin
      pop[i] = |g[i];
    end
    for (int j = 0; j < DIM_N; j++) begin
      for (int i = 0; i < DIM_N; i++) begin
        if (g[i][j]) begin
          col_grant[j] = 1'b1;
          odata_nxt[j] = head_data[i];
        end
      end
      ovf[j] = credit_i[j] && !col_grant[j] && (credit[j] == CMAX);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DIM_N; i++) begin
      if (store[i]) begin
        mem_data[i][wptr[i]] <= in_data_i[i];
        mem_dest[i][wptr[i]] <= in_dest_i[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM_N; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DIM_N; i++) begin
        if (store[i]) wptr[i] <= wptr[i] + PTR1;
        if (pop[i])   rptr[i] <= rptr[i] + PTR1;
        unique case ({store[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT1;
          2'b01:   count[i] <= count[i] - CNT1;
          default: ;
        endcase
      end
    end
  end

  // A credit returned at a full counter saturates and flags the error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DIM_N; j++) begin
        credit[j] <= CMAX;
      end
      out_vld_o  <= '0;
      out_data_o <= '0;
      err_o      <= 1'b0;
    end else begin
      out_vld_o  <= col_grant;
      out_data_o <= odata_nxt;
      if ((|bad) || (|ovf)) err_o <= 1'b1;
      for (int j = 0; j < DIM_N; j++) begin
        if (col_grant[j] && !credit_i[j]) begin
          credit[j] <= credit[j] - CR1;
        end else if (!col_grant[j] && credit_i[j]
                     && (credit[j] != CMAX)) begin
          credit[j] <= credit[j] + CR1;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_router_ingress.sv
// tb_noc_router_ingress: directed and randomized checks of the router
// ingress against a queue-based reference model.
module tb_noc_router_ingress;

  localparam int N     = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CRED  = 4;
  localparam int DIMW  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]         s_vld = '0;
  logic [N-1:0][DW-1:0] s_data = '0;
  logic [N-1:0][DIMW-1:0] s_dest = '0;
  logic [N-1:0][N-1:0]  s_grn = '0;
  logic [N-1:0]         s_cred = '0;

  logic [N-1:0]         in_rdy;
  logic [N-1:0][N-1:0]  req;
  logic [N-1:0]         out_vld;
  logic [N-1:0][DW-1:0] out_data;
  logic                 err;

  int checks = 0;
  int errors = 0;

  int                qdest [N][$];
  logic [DW-1:0]     qdata [N][$];
  int                cred  [N];
  logic [N-1:0]         m_vld;
  logic [N-1:0][DW-1:0] m_data;
  logic                 m_err;

  noc_router_ingress #(
    .DIM_N(N), .DATA_W(DW), .DEPTH(DEPTH), .CREDITS(CRED)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_vld_i(s_vld),
    .in_rdy_o(in_rdy),
    .in_data_i(s_data),
    .in_dest_i(s_dest),
    .req_o(req),
    .grn_i(s_grn),
    .out_vld_o(out_vld),
    .out_data_o(out_data),
    .credit_i(s_cred),
    .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0][N-1:0] m_req();
    logic [N-1:0][N-1:0] r = '0;
    for (int i = 0; i < N; i++)
      if (qdest[i].size() > 0 && cred[qdest[i][0]] > 0)
        r[i][qdest[i][0]] = 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0] m_rdy();
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = (qdest[i].size() < DEPTH);
    return r;
  endfunction

  function automatic logic [N-1:0][N-1:0] rand_grants(
    input logic [N-1:0][N-1:0] r);
    logic [N-1:0][N-1:0] g = '0;
    logic [N-1:0] urow = '0;
    logic [N-1:0] ucol = '0;
    int off = $urandom_range(0, N - 1);
    for (int k = 0; k < N; k++) begin
      int i = (k + off) % N;
      for (int j = 0; j < N; j++)
        if (r[i][j] && !ucol[j] && $urandom_range(0, 3) != 0) begin
          g[i][j] = 1'b1;
          urow[i] = 1'b1;
          ucol[j] = 1'b1;
        end
    end
    if ($urandom_range(0, 3) == 0) begin
      int si = $urandom_range(0, N - 1);
      int sj = $urandom_range(0, N - 1);
      if (!urow[si] && !ucol[sj] && !r[si][sj]) g[si][sj] = 1'b1;
    end
    return g;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      qdest[i].delete();
      qdata[i].delete();
      cred[i] = CRED;
    end
    m_vld = '0;
    m_data = '0;
    m_err = 1'b0;
  endtask

  // Advance model and DUT by one clock using the stimulus now applied.
  task automatic tick();
    logic [N-1:0][N-1:0] r;
    logic [N-1:0][N-1:0] g;
    logic [N-1:0] rdy;
    logic [N-1:0] col;
    r = m_req();
    rdy = m_rdy();
    g = s_grn & r;
    col = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        if (g[i][j]) begin
          col[j] = 1'b1;
          m_data[j] = qdata[i][0];
        end
    for (int i = 0; i < N; i++)
      if (|g[i]) begin
        void'(qdest[i].pop_front());
        void'(qdata[i].pop_front());
      end
    for (int j = 0; j < N; j++) begin
      if (col[j] && !s_cred[j]) cred[j]--;
      else if (!col[j] && s_cred[j]) begin
        if (cred[j] == CRED) m_err = 1'b1;
        else cred[j]++;
      end
    end
    for (int i = 0; i < N; i++)
      if (s_vld[i] && rdy[i]) begin
        qdest[i].push_back(int'(s_dest[i]));
        qdata[i].push_back(s_data[i]);
      end
    m_vld = col;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_stim();
    s_vld = '0;
    s_data = '0;
    s_dest = '0;
    s_grn = '0;
    s_cred = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_stim();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_stim();
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (in_rdy !== '1) begin
      errors++; $display("FAIL reset_rdy got %h want ff", in_rdy);
    end
    checks++;
    if (req !== '0) begin
      errors++; $display("FAIL reset_req got %h want 0", req);
    end
    checks++;
    if (out_vld !== '0) begin
      errors++; $display("FAIL reset_vld got %h want 0", out_vld);
    end
    checks++;
    if (out_data !== '0) begin
      errors++; $display("FAIL reset_data got %h want 0", out_data);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b want 0", err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    do_reset();
    s_vld[0] = 1'b1;
    s_dest[0] = 3'd3;
    s_data[0] = 32'hA5;
    tick();
    s_vld = '0;
    checks++;
    if (req[0][3] !== 1'b1 || req !== m_req()) begin
      errors++; $display("FAIL lat_req got %h want %h", req, m_req());
    end
    s_grn[0][3] = 1'b1;
    tick();
    s_grn = '0;
    checks++;
    if (out_vld !== 8'h08) begin
      errors++; $display("FAIL lat_vld got %h want 08", out_vld);
    end
    checks++;
    if (out_data[3] !== 32'hA5) begin
      errors++; $display("FAIL lat_data got %h want a5", out_data[3]);
    end
    checks++;
    if (int'(dut.credit[3]) != 3) begin
      errors++; $display("FAIL lat_credit got %0d want 3", dut.credit[3]);
    end
    tick();
    checks++;
    if (out_vld !== '0 || out_data[3] !== 32'hA5) begin
      errors++;
      $display("FAIL lat_hold got %h/%h want 0/a5", out_vld, out_data[3]);
    end
  endtask

  task automatic test_fifo_order();
    int dst [4];
    do_reset();
    for (int rd = 0; rd < 3; rd++) begin
      for (int k = 0; k < 4; k++) begin
        dst[k] = $urandom_range(0, N - 1);
        s_vld[2] = 1'b1;
        s_dest[2] = DIMW'(dst[k]);
        s_data[2] = DW'(rd * 16 + k + 1);
        checks++;
        if (in_rdy[2] !== 1'b1) begin
          errors++; $display("FAIL fill_rdy got %b want 1", in_rdy[2]);
        end
        tick();
      end
      s_data[2] = 32'hDEAD;
      checks++;
      if (in_rdy[2] !== 1'b0) begin
        errors++; $display("FAIL full_rdy got %b want 0", in_rdy[2]);
      end
      tick();
      s_vld = '0;
      for (int k = 0; k < 4; k++) begin
        s_grn = m_req();
        s_cred = m_vld;
        tick();
        checks++;
        if (out_vld[dst[k]] !== 1'b1
            || out_data[dst[k]] !== DW'(rd * 16 + k + 1)) begin
          errors++;
          $display("FAIL order got %b/%h want 1/%h", out_vld[dst[k]],
                   out_data[dst[k]], DW'(rd * 16 + k + 1));
        end
      end
      s_grn = '0;
      s_cred = m_vld;
      tick();
      s_cred = '0;
      checks++;
      if (in_rdy[2] !== 1'b1 || req[2] !== '0) begin
        errors++;
        $display("FAIL drained got %b/%h want 1/0", in_rdy[2], req[2]);
      end
    end
  endtask

  task automatic test_credit_stall();
    int sent = 0;
    int got = 0;
    logic [N-1:0] rdy;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      rdy = m_rdy();
      s_vld[4] = (sent < 5);
      s_dest[4] = 3'd5;
      s_data[4] = DW'(100 + sent);
      if (s_vld[4] && rdy[4]) sent++;
      s_grn = m_req();
      tick();
      if (out_vld[5]) begin
        checks++;
        if (out_data[5] !== DW'(100 + got)) begin
          errors++;
          $display("FAIL stall_data got %h want %h", out_data[5],
                   DW'(100 + got));
        end
        got++;
      end
    end
    clear_stim();
    checks++;
    if (got != 4 || req[4] !== '0) begin
      errors++;
      $display("FAIL stall_block got %0d/%h want 4/0", got, req[4]);
    end
    s_cred[5] = 1'b1;
    tick();
    s_cred = '0;
    checks++;
    if (req[4][5] !== 1'b1) begin
      errors++; $display("FAIL stall_reqback got %b want 1", req[4][5]);
    end
    s_grn = m_req();
    tick();
    s_grn = '0;
    if (out_vld[5]) begin
      checks++;
      if (out_data[5] !== DW'(104)) begin
        errors++; $display("FAIL stall_last got %h want 68", out_data[5]);
      end
      got++;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (out_vld[5]) got++;
    end
    checks++;
    if (got != 5) begin
      errors++; $display("FAIL stall_total got %0d want 5", got);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    s_grn[1][6] = 1'b1;
    tick();
    s_grn = '0;
    checks++;
    if (out_vld !== '0 || int'(dut.credit[6]) != CRED) begin
      errors++;
      $display("FAIL spur_empty got %h/%0d want 0/4", out_vld,
               dut.credit[6]);
    end
    s_vld[1] = 1'b1; s_dest[1] = 3'd2; s_data[1] = 32'h12;
    tick();
    s_vld = '0;
    s_grn[1][6] = 1'b1;
    tick();
    s_grn = '0;
    checks++;
    if (out_vld !== '0 || req[1][2] !== 1'b1) begin
      errors++;
      $display("FAIL spur_nopop got %h/%b want 0/1", out_vld, req[1][2]);
    end
    s_grn[1][2] = 1'b1;
    tick();
    s_grn = '0;
    s_vld[1] = 1'b1; s_dest[1] = 3'd6; s_data[1] = 32'h66;
    tick();
    s_vld = '0;
    s_grn[1][6] = 1'b1;
    tick();
    s_grn = '0;
    s_vld[1] = 1'b1; s_dest[1] = 3'd6; s_data[1] = 32'h67;
    tick();
    s_vld = '0;
    s_grn[1][6] = 1'b1;
    s_cred[6] = 1'b1;
    tick();
    clear_stim();
    checks++;
    if (int'(dut.credit[6]) != cred[6] || cred[6] != 3) begin
      errors++;
      $display("FAIL grant_and_credit got %0d want 3", dut.credit[6]);
    end
    checks++;
    if (out_vld[6] !== 1'b1 || out_data[6] !== 32'h67 || err !== 1'b0) begin
      errors++;
      $display("FAIL gc_out got %b/%h/%b want 1/67/0", out_vld[6],
               out_data[6], err);
    end
  endtask

  task automatic test_overflow_reset();
    do_reset();
    s_cred[0] = 1'b1;
    tick();
    s_cred = '0;
    checks++;
    if (err !== 1'b1 || err !== m_err) begin
      errors++; $display("FAIL ovf_err got %b want 1", err);
    end
    tick();
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got %b want 1", err);
    end
    for (int i = 0; i < N; i++) begin
      s_vld[i] = 1'b1;
      s_dest[i] = DIMW'($urandom_range(0, N - 1));
      s_data[i] = $urandom;
    end
    tick();
    s_grn = rand_grants(m_req());
    tick();
    s_grn = m_req() & ~s_grn;
    s_grn = rand_grants(m_req());
    tick();
    checks++;
    if (out_vld !== m_vld || req !== m_req()) begin
      errors++;
      $display("FAIL burst got %h/%h want %h/%h", out_vld, req, m_vld,
               m_req());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0 || out_vld !== '0 || req !== '0 || in_rdy !== '1) begin
      errors++;
      $display("FAIL midreset got %b/%h/%h/%h want 0/0/0/ff", err, out_vld,
               req, in_rdy);
    end
    clear_stim();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < N; i++) s_grn[i][(i + 1) % N] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++) begin
        s_vld[i] = 1'b1;
        s_dest[i] = DIMW'((i + 1) % N);
        s_data[i] = $urandom;
      end
      s_cred = m_vld;
      tick();
      checks++;
      if (out_vld !== m_vld || out_data !== m_data) begin
        errors++;
        $display("FAIL b2b_out got %h/%h want %h/%h", out_vld, out_data,
                 m_vld, m_data);
      end
      checks++;
      if (in_rdy !== m_rdy() || req !== m_req()) begin
        errors++;
        $display("FAIL b2b_ctl got %h/%h want %h/%h", in_rdy, req,
                 m_rdy(), m_req());
      end
      if (c >= 2) begin
        checks++;
        if (out_vld !== '1) begin
          errors++; $display("FAIL b2b_rate got %h want ff", out_vld);
        end
      end
    end
    s_vld = '0;
    for (int c = 0; c < 4; c++) begin
      s_cred = m_vld;
      tick();
    end
    clear_stim();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        s_vld[i] = ($urandom_range(0, 1) == 1);
        s_dest[i] = DIMW'($urandom_range(0, N - 1));
        s_data[i] = $urandom;
        s_cred[i] = (cred[i] < CRED) && ($urandom_range(0, 1) == 1);
      end
      s_grn = rand_grants(m_req());
      tick();
      checks++;
      if (out_vld !== m_vld || out_data !== m_data) begin
        errors++;
        $display("FAIL rnd_out c%0d got %h/%h want %h/%h", c, out_vld,
                 out_data, m_vld, m_data);
      end
      checks++;
      if (in_rdy !== m_rdy() || req !== m_req()) begin
        errors++;
        $display("FAIL rnd_ctl c%0d got %h/%h want %h/%h", c, in_rdy, req,
                 m_rdy(), m_req());
      end
      checks++;
      if (err !== m_err) begin
        errors++; $display("FAIL rnd_err c%0d got %b want %b", c, err, m_err);
      end
    end
    clear_stim();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fifo_order();
    test_credit_stall();
    test_spurious();
    test_overflow_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
